// File: rtl/shift_pkg.sv
// Shared types for the shift pipeline.
// Shift op encoding and shift-amount field width.
package shift_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } shift_op_t;

endpackage

// File: rtl/shift_stage.sv
// Combinational shift by cnt*STEP for one pipeline stage.
// Ports: data/op/cnt in, res out; PASS returns data.
module shift_stage
  import shift_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 8,
  parameter int MAX  = 3,
  parameter int CW   = $clog2(MAX + 1)
) (
  input  logic [N-1:0]  data,
  input  shift_op_t     op,
  input  logic [CW-1:0] cnt,
  output logic [N-1:0]  res
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] amt;

  assign amt = SW'(cnt) * SW'(STEP);

  always_comb begin
    res = data;
    unique case (op)
      OP_SLL:  res = data << amt;
      OP_SRL:  res = data >> amt;
      OP_SRA:  res = $unsigned($signed(data) >>> amt);
      OP_PASS: res = data;
      default: res = data;
    endcase
  end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage barrel shifter: coarse (x8) then fine (x1).
// Ports: in_* valid/ready operation, out_* valid/ready result, op_count.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [N-1:0] in_shamt,
  input  shift_op_t    in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [15:0]  op_count
);

  typedef struct packed {
    logic [N-1:0] data;
    shift_op_t    op;
    logic [2:0]   fine;
  } s1_t;

  logic               s1_valid;
  s1_t                s1;
  logic               s2_valid;
  logic [N-1:0]       s2_data;
  logic [SHAMT_W-1:0] amt;
  logic [N-1:0]       coarse_res;
  logic [N-1:0]       fine_res;
  logic               adv;
  logic               fire;
  logic               unused_shamt;

  assign amt          = in_shamt[SHAMT_W-1:0];
  assign unused_shamt = ^in_shamt[N-1:SHAMT_W];

  // Stage 2 moves when it is empty or being drained;
  // stage 1 can refill whenever it is empty or moving.
  assign adv      = !s2_valid | out_ready;
  assign in_ready = !s1_valid | adv;
  assign fire     = in_valid & in_ready;

  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  shift_stage #(
    .N(N), .STEP(8), .MAX(3)
  ) u_coarse (
    .data (in_data),
    .op   (in_op),
    .cnt  (amt[4:3]),
    .res  (coarse_res)
  );

  shift_stage #(
    .N(N), .STEP(1), .MAX(7)
  ) u_fine (
    .data (s1.data),
    .op   (s1.op),
    .cnt  (s1.fine),
    .res  (fine_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      op_count <= '0;
    end else begin
      if (in_ready)
        s1_valid <= in_valid;
      if (fire)
        s1 <= '{data: coarse_res,
                op:   in_op,
                fine: amt[2:0]};
      if (adv) begin
        s2_valid <= s1_valid;
        if (s1_valid)
          s2_data <= fine_res;
      end
      if (s2_valid & out_ready)
        op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe.
// Hand-computed vectors, stall, reset flush, op_count wrap.
module tb_shift_pipe;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_shamt;
  shift_op_t   in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] op_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] cnt_exp = 16'd0;

  logic [31:0] tp_d [4];
  logic [31:0] tp_s [4];
  shift_op_t   tp_o [4];
  logic [31:0] tp_e [4];

  always #5 clk = ~clk;

  shift_pipe #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .op_count  (op_count)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic [31:0] d,
    input logic [31:0] s,
    input shift_op_t   o
  );
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = o;
  endtask

  task automatic run_one(
    input string       tag,
    input logic [31:0] d,
    input logic [31:0] s,
    input shift_op_t   o,
    input logic [31:0] exp
  );
    @(negedge clk);
    out_ready = 1'b1;
    drive(d, s, o);
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hA5A5_A5A5;
    in_shamt = 32'h0000_0013;
    in_op    = OP_SLL;
    @(negedge clk);
    check({tag, ".v1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, ".v2"}, 32'(out_valid), 32'd1);
    check(tag, out_data, exp);
    @(posedge clk);
    cnt_exp++;
    @(negedge clk);
    check({tag, ".cnt"}, 32'(op_count), 32'(cnt_exp));
    check({tag, ".v3"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    cnt_exp  = 16'd0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = OP_SLL;
    out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst.ov", 32'(out_valid), 32'd0);
    check("rst.od", out_data, 32'd0);
    check("rst.cnt", 32'(op_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.rdy", 32'(in_ready), 32'd1);
    check("rst.ov2", 32'(out_valid), 32'd0);

    // single operations
    run_one("srl31", 32'h8000_0000, 32'd31,
            OP_SRL, 32'h0000_0001);
    run_one("sra_neg", 32'h8000_0000, 32'd4,
            OP_SRA, 32'hF800_0000);
    run_one("sra_pos", 32'h7000_0000, 32'd4,
            OP_SRA, 32'h0700_0000);
    run_one("sll_hi", 32'h0000_0001, 32'h21,
            OP_SLL, 32'h0000_0002);
    run_one("pass", 32'h1234_5678, 32'd9,
            OP_PASS, 32'h1234_5678);
    run_one("sll0", 32'hDEAD_BEEF, 32'd0,
            OP_SLL, 32'hDEAD_BEEF);
    run_one("sra0", 32'hDEAD_BEEF, 32'hFFFF_FFE0,
            OP_SRA, 32'hDEAD_BEEF);
    run_one("sra31", 32'h8000_0000, 32'd31,
            OP_SRA, 32'hFFFF_FFFF);
    run_one("sll_ign", 32'h0000_0001, 32'hFFFF_FFE3,
            OP_SLL, 32'h0000_0008);
    run_one("srl12", 32'hF000_0000, 32'd12,
            OP_SRL, 32'h000F_0000);
    run_one("sll16", 32'h0000_00AB, 32'd16,
            OP_SLL, 32'h00AB_0000);

    // back-to-back throughput
    tp_d = '{32'h0000_00FF, 32'h8000_0001,
             32'hFFFF_0000, 32'h0F0F_0F0F};
    tp_s = '{32'd8, 32'd1, 32'd17, 32'd7};
    tp_o = '{OP_SLL, OP_SRA, OP_SRL, OP_PASS};
    tp_e = '{32'h0000_FF00, 32'hC000_0000,
             32'h0000_7FFF, 32'h0F0F_0F0F};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("tp.rdy", 32'(in_ready), 32'd1);
      if (k >= 2) begin
        check("tp.ov", 32'(out_valid), 32'd1);
        check("tp.od", out_data, tp_e[k-2]);
      end else begin
        check("tp.ov0", 32'(out_valid), 32'd0);
      end
      if (k < 4)
        drive(tp_d[k], tp_s[k], tp_o[k]);
      else
        in_valid = 1'b0;
    end
    @(negedge clk);
    cnt_exp += 16'd4;
    check("tp.end", 32'(out_valid), 32'd0);
    check("tp.cnt", 32'(op_count), 32'(cnt_exp));

    // stall with out_ready low
    do_reset();
    drive(32'h0000_0001, 32'd4, OP_SLL);
    check("st.r0", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("st.r1", 32'(in_ready), 32'd1);
    check("st.v1", 32'(out_valid), 32'd0);
    drive(32'hFF00_0000, 32'd8, OP_SRL);
    @(negedge clk);
    check("st.r2", 32'(in_ready), 32'd0);
    check("st.v2", 32'(out_valid), 32'd1);
    check("st.a", out_data, 32'h0000_0010);
    drive(32'h8000_0010, 32'd4, OP_SRA);
    @(negedge clk);
    check("st.r3", 32'(in_ready), 32'd0);
    check("st.hold", out_data, 32'h0000_0010);
    out_ready = 1'b1;
    #1;
    check("st.r4", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("st.b", out_data, 32'h00FF_0000);
    drive(32'hCAFE_BABE, 32'd31, OP_PASS);
    @(negedge clk);
    check("st.c", out_data, 32'hF800_0001);
    in_valid = 1'b0;
    @(negedge clk);
    check("st.vd", 32'(out_valid), 32'd1);
    check("st.d", out_data, 32'hCAFE_BABE);
    @(negedge clk);
    check("st.end", 32'(out_valid), 32'd0);
    check("st.cnt", 32'(op_count), 32'd4);

    // reset with both stages full
    out_ready = 1'b0;
    drive(32'h0000_0003, 32'd1, OP_SLL);
    @(negedge clk);
    drive(32'h0000_0005, 32'd1, OP_SLL);
    @(negedge clk);
    check("fl.full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    drive(32'h0000_0007, 32'd1, OP_SLL);
    @(negedge clk);
    check("fl.ov", 32'(out_valid), 32'd0);
    check("fl.cnt", 32'(op_count), 32'd0);
    check("fl.od", out_data, 32'd0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_exp   = 16'd0;
    @(negedge clk);
    check("fl.rdy", 32'(in_ready), 32'd1);
    check("fl.ov1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("fl.ov2", 32'(out_valid), 32'd0);
    check("fl.cnt2", 32'(op_count), 32'd0);

    // op_count wrap
    do_reset();
    out_ready = 1'b1;
    drive(32'h0000_0001, 32'd1, OP_SLL);
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("wr.ffff", 32'(op_count), 32'h0000_FFFF);
    check("wr.ov", 32'(out_valid), 32'd0);
    cnt_exp = 16'hFFFF;
    run_one("wr.last", 32'h0000_0001, 32'd1,
            OP_SLL, 32'h0000_0002);
    check("wr.zero", 32'(op_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
